// File: rtl/sid_audio_pkg.sv
// ----------------------------------------------------------------------------
// sid_audio_pkg
//   Shared definitions for the SID audio path: sample width, the signed
//   sample type, and the default decimation and FIFO depth constants used
//   by sid_sample_decimator and sid_sample_fifo.
// ----------------------------------------------------------------------------
package sid_audio_pkg;

    // Width of one SID / I2S audio sample
    localparam int unsigned SAMPLE_W = 16;

    // Default log2 of the decimation ratio (32 SID samples per output)
    localparam int unsigned DEF_LOG2_DEC = 5;

    // Default log2 of the output FIFO depth (8 entries)
    localparam int unsigned DEF_LOG2_DEPTH = 3;

    // Signed two's-complement audio sample
    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : sid_audio_pkg

// File: rtl/sid_sample_fifo.sv
// ----------------------------------------------------------------------------
// sid_sample_fifo
//   Synchronous FIFO holding decimated audio samples for the I2S encoder.
//   The head word is visible combinationally on 'head'; the consumer latches
//   it on the same edge that it pops.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data (accepted when not full, or when a pop
//                   happens in the same cycle)
//   push_data  in   sample to write
//   pop        in   discard the head word (ignored when empty)
//   head       out  word at the read pointer
//   level      out  occupancy, 0..2^LOG2_DEPTH
//   full       out  level == 2^LOG2_DEPTH
//   empty      out  level == 0
// ----------------------------------------------------------------------------
module sid_sample_fifo
    import sid_audio_pkg::*;
#(
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  push,
    input  sample_t               push_data,
    input  logic                  pop,
    output sample_t               head,
    output logic [LOG2_DEPTH:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

    sample_t               mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Full and empty come from the occupancy count; pointers alone cannot
    // tell the two apart once they wrap.
    assign full  = (level == (LOG2_DEPTH+1)'(DEPTH));
    assign empty = (level == '0);

    assign pop_ok  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written: wr_ptr
    // equals rd_ptr, and the old head is read before the write lands.
    assign push_ok = push && (!full || pop_ok);

    assign head = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule : sid_sample_fifo

// File: rtl/sid_sample_decimator.sv
// ----------------------------------------------------------------------------
// sid_sample_decimator
//   Box-car averages 2^LOG2_DEC consecutive SID samples (one per clk_en) into
//   one decimated sample, buffers the results in a small FIFO, and presents
//   them one at a time to the I2S encoder. Decouples the fixed SID rate from
//   the externally clocked I2S frame rate.
//
// Ports:
//   sys_clk       in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   clk_en        in   1 MHz SID enable, one sys_clk wide
//   sample_in     in   signed SID sample, valid while clk_en=1
//   sample_taken  in   encoder has latched sample_out; advance to next word
//   clear_flags   in   clear sticky overflow/underflow
//   sample_out    out  registered sample presented to the encoder
//   level         out  FIFO occupancy, 0..2^LOG2_DEPTH
//   overflow      out  sticky: a decimated sample was dropped (FIFO full)
//   underflow     out  sticky: sample_taken arrived with the FIFO empty
// ----------------------------------------------------------------------------
module sid_sample_decimator
    import sid_audio_pkg::*;
#(
    parameter int unsigned LOG2_DEC   = DEF_LOG2_DEC,
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  sample_t               sample_in,
    input  logic                  sample_taken,
    input  logic                  clear_flags,
    output sample_t               sample_out,
    output logic [LOG2_DEPTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned ACC_W = SAMPLE_W + LOG2_DEC;

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shifted;
    logic [LOG2_DEC-1:0]     cnt;
    sample_t                 avg_next;
    sample_t                 avg;
    logic                    push_req;

    always_comb begin
        acc_sum     = acc + {{LOG2_DEC{sample_in[SAMPLE_W-1]}}, sample_in};
        // Arithmetic shift floors toward -inf; the mean of 16-bit samples
        // always fits back into 16 bits, so truncation is lossless.
        acc_shifted = acc_sum >>> LOG2_DEC;
        avg_next    = acc_shifted[SAMPLE_W-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            avg      <= '0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (clk_en) begin
                if (cnt == '1) begin
                    avg      <= avg_next;
                    push_req <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    sample_t fifo_head;
    logic    fifo_full;
    logic    fifo_empty;

    sid_sample_fifo #(
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (avg),
        .pop       (sample_taken),
        .head      (fifo_head),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Output register and sticky flags
    // ------------------------------------------------------------------
    logic pop_ok;
    logic set_overflow;
    logic set_underflow;

    assign pop_ok = sample_taken && !fifo_empty;
    // No bypass: an empty FIFO cannot serve a pop even if a push lands in
    // the same cycle, so that case still counts as an underflow.
    assign set_underflow = sample_taken && fifo_empty;
    // A full FIFO only drops the new word when nothing is popped alongside.
    assign set_overflow  = push_req && fifo_full && !pop_ok;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sample_out <= '0;
        end else if (pop_ok) begin
            sample_out <= fifo_head;
        end
    end

    // Set has priority over clear so that an event coinciding with
    // clear_flags is never lost.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_overflow) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (set_underflow) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule : sid_sample_decimator
